// File: rtl/rv_pkg.sv
// Shared RV32M definitions: M-extension funct3/funct7 encodings, XLEN and the
// muldiv state enum.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_t;

    // {in1 signed, in2 signed}; MUL is treated as unsigned since only its low word is kept
    function automatic logic [1:0] op_signs(logic [2:0] f3);
        logic [1:0] s;
        case (f3)
            F3_MULH, F3_DIV, F3_REM:               s = 2'b11;
            F3_MULHSU:                             s = 2'b10;
            F3_MUL, F3_MULHU, F3_DIVU, F3_REMU:    s = 2'b00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 step: shift-add multiply or restoring shift-subtract
// divide on a 64-bit {high, low} accumulator.
module muldiv_step import rv_pkg::*; (
    input  logic                div_mode,
    input  logic [2*XLEN-1:0]   acc_in,
    input  logic [XLEN-1:0]     b,
    output logic [2*XLEN-1:0]   acc_out
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    always_comb begin
        sum    = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, b} : '0);
        rem_sh = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-1]};
        diff   = rem_sh - {1'b0, b};
        if (!div_mode) begin
            acc_out = {sum, acc_in[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            acc_out = {diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
        end else begin
            acc_out = {rem_sh[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv.sv
// Iterative RV32M multiply/divide unit with valid/ready request and response.
// Define MULDIV_EARLY_OUT_EN to send trivial cases down the 1-cycle path.
module muldiv import rv_pkg::*; (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   in1,
    input  logic [XLEN-1:0]   in2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   result,
    output logic              negative,
    output logic              zero,
    output logic              illegal
);

    muldiv_state_t      state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [2:0]         f3_q, f3_d;
    logic               sgn1_q, sgn1_d, sgn2_q, sgn2_d;
    logic               ill_q, ill_d;
    logic               use_spec_q, use_spec_d;
    logic [XLEN-1:0]    spec_res_q, spec_res_d;
    logic [2*XLEN-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]    b_q, b_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               illegal_q, illegal_d;
    logic               req_ready_q, req_ready_d;
    logic               resp_valid_q, resp_valid_d;

    logic [2*XLEN-1:0]  step_out;
    logic [1:0]         signs;
    logic               s1, s2, is_div, bad_f7, div0, ovf, mzero, early;
    logic [XLEN-1:0]    mag1, mag2, spec_res, quot, rem, fix_res;
    logic [2*XLEN-1:0]  prod;

    muldiv_step u_step (
        .div_mode (f3_q[2]),
        .acc_in   (acc_q),
        .b        (b_q),
        .acc_out  (step_out)
    );

    always_comb begin
        signs  = op_signs(funct3);
        s1     = signs[1] & in1[XLEN-1];
        s2     = signs[0] & in2[XLEN-1];
        mag1   = s1 ? -in1 : in1;
        mag2   = s2 ? -in2 : in2;
        is_div = funct3[2];
        bad_f7 = funct7 != FUNCT7_MULDIV;
        div0   = is_div && (in2 == '0);
        ovf    = is_div && !funct3[0] && (in1 == 32'h8000_0000) && (in2 == 32'hFFFF_FFFF);
        mzero  = !is_div && ((in1 == '0) || (in2 == '0));

        // Precomputed results for the RISC-V defined corner cases
        if (bad_f7)    spec_res = '0;
        else if (div0) spec_res = funct3[1] ? in1 : 32'hFFFF_FFFF;
        else if (ovf)  spec_res = funct3[1] ? 32'h0 : 32'h8000_0000;
        else           spec_res = '0;

`ifdef MULDIV_EARLY_OUT_EN
        early = bad_f7 | div0 | ovf | mzero;
`else
        early = bad_f7;
`endif

        prod    = (sgn1_q ^ sgn2_q) ? -acc_q : acc_q;
        quot    = (sgn1_q ^ sgn2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem     = sgn1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (use_spec_q)          fix_res = spec_res_q;
        else if (f3_q[2])        fix_res = f3_q[1] ? rem : quot;
        else if (f3_q == F3_MUL) fix_res = prod[XLEN-1:0];
        else                     fix_res = prod[2*XLEN-1:XLEN];

        state_d    = state_q;
        cnt_d      = cnt_q;
        f3_d       = f3_q;
        sgn1_d     = sgn1_q;
        sgn2_d     = sgn2_q;
        ill_d      = ill_q;
        use_spec_d = use_spec_q;
        spec_res_d = spec_res_q;
        acc_d      = acc_q;
        b_d        = b_q;
        result_d   = result_q;
        illegal_d  = illegal_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    f3_d       = funct3;
                    sgn1_d     = s1;
                    sgn2_d     = s2;
                    ill_d      = bad_f7;
                    use_spec_d = bad_f7 | div0 | ovf | mzero;
                    spec_res_d = spec_res;
                    acc_d      = {{XLEN{1'b0}}, mag1};
                    b_d        = mag2;
                    cnt_d      = '0;
                    state_d    = early ? FIX : CALC;
                end
            end
            CALC: begin
                acc_d = step_out;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIX;
            end
            FIX: begin
                result_d  = fix_res;
                illegal_d = ill_q;
                state_d   = DONE;
            end
            DONE: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        req_ready_d  = state_d == IDLE;
        resp_valid_d = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            f3_q         <= '0;
            sgn1_q       <= 1'b0;
            sgn2_q       <= 1'b0;
            ill_q        <= 1'b0;
            use_spec_q   <= 1'b0;
            spec_res_q   <= '0;
            acc_q        <= '0;
            b_q          <= '0;
            result_q     <= '0;
            illegal_q    <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            f3_q         <= f3_d;
            sgn1_q       <= sgn1_d;
            sgn2_q       <= sgn2_d;
            ill_q        <= ill_d;
            use_spec_q   <= use_spec_d;
            spec_res_q   <= spec_res_d;
            acc_q        <= acc_d;
            b_q          <= b_d;
            result_q     <= result_d;
            illegal_q    <= illegal_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign result     = result_q;
    assign negative   = result_q[XLEN-1];
    assign zero       = result_q == '0;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: arithmetic reference model, per-cycle compare
// of handshake/latency/result, directed corner cases and randomized operations.
module tb_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = 7'b0000001;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] result;
    logic        negative;
    logic        zero;
    logic        illegal;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic        mdl_active = 1'b0;
    int          edges = 0;
    int          exp_lat = 0;
    logic [31:0] exp_res = '0;
    logic        exp_ill = 1'b0;
    logic        chk_en = 1'b0;

    muldiv dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .in1        (in1),
        .in2        (in2),
        .funct3     (funct3),
        .funct7     (funct7),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .negative   (negative),
        .zero       (zero),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // Expected result, illegal flag and latency from the RV32M definitions
    task automatic model_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                            input logic [6:0] f7, output logic [31:0] res, output logic ill,
                            output int lat);
        logic [63:0] p;
        logic signed [31:0] sa, sb;
        logic div0, ovf, mz, special;
        sa = a;
        sb = b;
        div0 = f3[2] && (b == 0);
        ovf  = (f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        mz   = !f3[2] && (a == 0 || b == 0);
        res  = '0;
        case (f3)
            3'b000: begin p = {32'b0, a} * {32'b0, b}; res = p[31:0]; end
            3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; res = p[63:32]; end
            3'b010: begin p = {{32{a[31]}}, a} * {32'b0, b}; res = p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; res = p[63:32]; end
            3'b100: res = div0 ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'b101: res = div0 ? 32'hFFFF_FFFF : a / b;
            3'b110: res = div0 ? a : ovf ? 32'h0 : 32'(sa % sb);
            3'b111: res = div0 ? a : a % b;
        endcase
        ill = f7 != 7'b0000001;
        if (ill) res = '0;
        special = div0 | ovf | mz;
`ifdef MULDIV_EARLY_OUT_EN
        lat = (ill || special) ? 1 : 33;
`else
        lat = ill ? 1 : 33;
`endif
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model progression: acceptance, edge counting, response handshake
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mdl_active = 1'b0;
                edges = 0;
            end else if (mdl_active) begin
                if (edges >= exp_lat && resp_ready) mdl_active = 1'b0;
                else edges++;
            end else if (req_valid) begin
                model_op(in1, in2, funct3, funct7, exp_res, exp_ill, exp_lat);
                mdl_active = 1'b1;
                edges = 0;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && chk_en) begin
                if (mdl_active) begin
                    checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
                    checkOutput("resp_valid_latency", 32'(resp_valid), 32'(edges >= exp_lat));
                    if (resp_valid && edges >= exp_lat) begin
                        checkOutput("result", result, exp_res);
                        checkOutput("negative", 32'(negative), 32'(exp_res[31]));
                        checkOutput("zero", 32'(zero), 32'(exp_res == 0));
                        checkOutput("illegal", 32'(illegal), 32'(exp_ill));
                    end
                end else begin
                    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
                    checkOutput("resp_valid_idle", 32'(resp_valid), 32'd0);
                end
            end
        end
    end

    // One full transaction; lit_en pins the result to a hand-computed value
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                                 input logic [6:0] f7, input int bp, input logic lit_en,
                                 input logic [31:0] lit);
        bit got = 0;
        @(negedge clk);
        in1 = a; in2 = b; funct3 = f3; funct7 = f7;
        req_valid = 1'b1;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        in1 = $urandom; in2 = $urandom; funct3 = 3'($urandom); funct7 = 7'($urandom);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (resp_valid) begin got = 1; break; end
            req_valid = 1'($urandom);
        end
        req_valid = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("[TB] FAIL resp_timeout: no resp_valid within 50 cycles (f3=%0d)", f3);
        end else if (lit_en) begin
            checkOutput("literal_result", result, lit);
        end
        if (bp > 0) begin
            req_valid = 1'b1;
            repeat (bp) @(negedge clk);
            req_valid = 1'b0;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1 rst_n = 1'b0;
        #20;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset_result", result, 32'h0);
        checkOutput("reset_negative", 32'(negative), 32'd0);
        checkOutput("reset_zero", 32'(zero), 32'd1);
        checkOutput("reset_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        applyStimulus(32'd7,          32'hFFFF_FFFD, 3'b000, 7'h01, 0, 1, 32'hFFFF_FFEB);
        applyStimulus(32'hFFFF_FFFF,  32'hFFFF_FFFF, 3'b011, 7'h01, 0, 1, 32'hFFFF_FFFE);
        applyStimulus(32'hFFFF_FFFF,  32'hFFFF_FFFF, 3'b001, 7'h01, 0, 1, 32'h0000_0000);
        applyStimulus(32'hFFFF_FFFF,  32'd2,         3'b010, 7'h01, 0, 1, 32'hFFFF_FFFF);
        applyStimulus(32'hFFFF_FFEC,  32'd3,         3'b100, 7'h01, 0, 1, 32'hFFFF_FFFA);
        applyStimulus(32'hFFFF_FFEC,  32'd3,         3'b110, 7'h01, 0, 1, 32'hFFFF_FFFE);
        applyStimulus(32'd100,        32'd7,         3'b101, 7'h01, 0, 1, 32'd14);
        applyStimulus(32'd100,        32'd7,         3'b111, 7'h01, 0, 1, 32'd2);
        applyStimulus(32'd5,          32'd0,         3'b101, 7'h01, 0, 1, 32'hFFFF_FFFF);
        applyStimulus(32'd5,          32'd0,         3'b110, 7'h01, 0, 1, 32'd5);
        applyStimulus(32'h8000_0000,  32'hFFFF_FFFF, 3'b100, 7'h01, 0, 1, 32'h8000_0000);
        applyStimulus(32'h8000_0000,  32'hFFFF_FFFF, 3'b110, 7'h01, 0, 1, 32'h0);
        applyStimulus(32'd9,          32'd0,         3'b000, 7'h01, 0, 1, 32'h0);
        applyStimulus(32'hFFFF_FFEC,  32'd3,         3'b100, 7'h01, 5, 1, 32'hFFFF_FFFA);
        applyStimulus(32'd12,         32'd5,         3'b000, 7'h00, 0, 1, 32'h0);
        applyStimulus(32'd12,         32'd5,         3'b000, 7'h01, 2, 1, 32'd60);

        // abort during CALC step 10
        @(negedge clk);
        in1 = 32'd1234; in2 = 32'd5678; funct3 = 3'b000; funct7 = 7'h01;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
        checkOutput("abort_result", result, 32'h0);
        checkOutput("abort_zero", 32'(zero), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'd3, 32'd4, 3'b000, 7'h01, 0, 1, 32'd12);

        for (int n = 0; n < 150; n++) begin
            logic [6:0] f7;
            f7 = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'h01;
            applyStimulus(pick_operand(), pick_operand(), 3'($urandom), f7,
                          ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0, 0, 32'h0);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
